// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: trap/mret bookkeeping, 64-bit cycle and
// instret counters, combinational read port and a write-back stage write port.
module csr_regfile #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [11:0] i_csr_rd_addr,
  output logic [31:0] o_csr_rd_data,
  output logic        o_csr_rd_illegal,
  input  logic        i_csr_wr_en,
  input  logic [11:0] i_csr_wr_addr,
  input  logic [31:0] i_csr_wr_data,
  input  logic        i_insn_retire,
  input  logic        i_trap_valid,
  input  logic [31:0] i_trap_cause,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_tval,
  input  logic        i_mret,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc,
  output logic        o_mstatus_mie
);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL      = 32'h4000_0100;
  localparam logic [31:0] MTVEC_RST_VAL = MTVEC_RESET & ~32'h3;

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle_q;
  logic [63:0] mcycle_d;
  logic [63:0] minstret_q;
  logic [63:0] minstret_d;

  logic        wr_ok;
  logic [31:0] mstatus_rd;

  // A trap swallows the write entirely; the user-level shadow space is read-only.
  assign wr_ok = i_csr_wr_en && !i_trap_valid && (i_csr_wr_addr[11:10] != 2'b11);

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

  // Combinational read mux; no forwarding of the write in flight.
  always_comb begin
    o_csr_rd_data    = 32'h0;
    o_csr_rd_illegal = 1'b0;
    case (i_csr_rd_addr)
      CSR_MSTATUS:                 o_csr_rd_data = mstatus_rd;
      CSR_MISA:                    o_csr_rd_data = MISA_VAL;
      CSR_MIE:                     o_csr_rd_data = mie_q;
      CSR_MTVEC:                   o_csr_rd_data = mtvec_q;
      CSR_MSCRATCH:                o_csr_rd_data = mscratch_q;
      CSR_MEPC:                    o_csr_rd_data = mepc_q;
      CSR_MCAUSE:                  o_csr_rd_data = mcause_q;
      CSR_MTVAL:                   o_csr_rd_data = mtval_q;
      CSR_MIP:                     o_csr_rd_data = 32'h0;
      CSR_MCYCLE, CSR_CYCLE:       o_csr_rd_data = mcycle_q[31:0];
      CSR_MINSTRET, CSR_INSTRET:   o_csr_rd_data = minstret_q[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     o_csr_rd_data = mcycle_q[63:32];
      CSR_MINSTRETH, CSR_INSTRETH: o_csr_rd_data = minstret_q[63:32];
      CSR_MHARTID:                 o_csr_rd_data = HART_ID;
      default:                     o_csr_rd_illegal = 1'b1;
    endcase
  end

  // Counter next-state: a write to either half replaces it and skips that cycle's increment.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (wr_ok && i_csr_wr_addr == CSR_MCYCLE) begin
      mcycle_d = {mcycle_q[63:32], i_csr_wr_data};
    end else if (wr_ok && i_csr_wr_addr == CSR_MCYCLEH) begin
      mcycle_d = {i_csr_wr_data, mcycle_q[31:0]};
    end

    minstret_d = minstret_q + {63'd0, i_insn_retire};
    if (wr_ok && i_csr_wr_addr == CSR_MINSTRET) begin
      minstret_d = {minstret_q[63:32], i_csr_wr_data};
    end else if (wr_ok && i_csr_wr_addr == CSR_MINSTRETH) begin
      minstret_d = {i_csr_wr_data, minstret_q[31:0]};
    end
  end

  // Counter registers; they keep running through trap and mret cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Trap/mret/write state update, highest priority first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= MTVEC_RST_VAL;
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
    end else if (i_trap_valid) begin
      mepc_q         <= i_trap_pc & ~32'h3;
      mcause_q       <= i_trap_cause;
      mtval_q        <= i_trap_tval;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else begin
      if (i_mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (wr_ok && i_csr_wr_addr == CSR_MSTATUS) begin
        mstatus_mie_q  <= i_csr_wr_data[3];
        mstatus_mpie_q <= i_csr_wr_data[7];
      end
      if (wr_ok && i_csr_wr_addr == CSR_MIE)      mie_q      <= i_csr_wr_data;
      if (wr_ok && i_csr_wr_addr == CSR_MTVEC)    mtvec_q    <= i_csr_wr_data & ~32'h3;
      if (wr_ok && i_csr_wr_addr == CSR_MSCRATCH) mscratch_q <= i_csr_wr_data;
      if (wr_ok && i_csr_wr_addr == CSR_MEPC)     mepc_q     <= i_csr_wr_data & ~32'h3;
      if (wr_ok && i_csr_wr_addr == CSR_MCAUSE)   mcause_q   <= i_csr_wr_data;
      if (wr_ok && i_csr_wr_addr == CSR_MTVAL)    mtval_q    <= i_csr_wr_data;
    end
  end

  assign o_mtvec       = mtvec_q;
  assign o_mepc        = mepc_q;
  assign o_mstatus_mie = mstatus_mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: expectations are queued as stimulus is
// applied and drained through the read port / direct outputs after the edge.
module tb_csr_regfile;

  logic        clk;
  logic        rst;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_ill;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        retire;
  logic        trap;
  logic [31:0] t_cause;
  logic [31:0] t_pc;
  logic [31:0] t_tval;
  logic        mret;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] mcyc_model = 64'd0;

  localparam int K_RD    = 0;
  localparam int K_MTVEC = 1;
  localparam int K_MEPC  = 2;
  localparam int K_MIE   = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [11:0] addr;
    logic [31:0] exp;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];

  csr_regfile #(
    .MTVEC_RESET(32'h0000_1003),
    .HART_ID    (32'd5)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_csr_rd_addr   (rd_addr),
    .o_csr_rd_data   (rd_data),
    .o_csr_rd_illegal(rd_ill),
    .i_csr_wr_en     (wr_en),
    .i_csr_wr_addr   (wr_addr),
    .i_csr_wr_data   (wr_data),
    .i_insn_retire   (retire),
    .i_trap_valid    (trap),
    .i_trap_cause    (t_cause),
    .i_trap_pc       (t_pc),
    .i_trap_tval     (t_tval),
    .i_mret          (mret),
    .o_mtvec         (mtvec_o),
    .o_mepc          (mepc_o),
    .o_mstatus_mie   (mie_o)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp,
                         input logic ill = 1'b0);
    exp_t e;
    e.tag = tag; e.kind = K_RD; e.addr = addr; e.exp = exp; e.ill = ill;
    sb_q.push_back(e);
  endtask

  task automatic push_out(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.addr = 12'h0; e.exp = exp; e.ill = 1'b0;
    sb_q.push_back(e);
  endtask

  // Called just after an edge; each read takes 1 time unit, well inside the half period.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_RD: begin
          rd_addr = e.addr;
          #1;
          check_val(e.tag, rd_data, e.exp);
          check_val({e.tag, "_ill"}, {31'b0, rd_ill}, {31'b0, e.ill});
        end
        K_MTVEC: check_val(e.tag, mtvec_o, e.exp);
        K_MEPC:  check_val(e.tag, mepc_o, e.exp);
        default: check_val(e.tag, {31'b0, mie_o}, e.exp);
      endcase
    end
  endtask

  // Advance one edge, updating the bench's own mcycle model from the driven inputs.
  task automatic tick();
    if (rst)
      mcyc_model = 64'd0;
    else if (wr_en && !trap && wr_addr == 12'hB00)
      mcyc_model = {mcyc_model[63:32], wr_data};
    else if (wr_en && !trap && wr_addr == 12'hB80)
      mcyc_model = {wr_data, mcyc_model[31:0]};
    else
      mcyc_model = mcyc_model + 64'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; trap = 1'b0; mret = 1'b0; retire = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
    trap = 1'b1; t_pc = pc; t_cause = cause; t_tval = tval;
  endtask

  initial begin
    rst = 1'b1; rd_addr = 12'h0; wr_addr = 12'h0; wr_data = 32'h0;
    t_pc = 32'h0; t_cause = 32'h0; t_tval = 32'h0;
    idle();
    tick(); tick();

    push_rd("rst_mstatus", 12'h300, 32'h0000_1800);
    push_rd("rst_mie", 12'h304, 32'h0);
    push_rd("rst_mtvec", 12'h305, 32'h0000_1000);
    push_rd("rst_mscratch", 12'h340, 32'h0);
    push_rd("rst_mcycle", 12'hB00, 32'h0);
    push_rd("rst_minstret", 12'hB02, 32'h0);
    push_out("rst_o_mtvec", K_MTVEC, 32'h0000_1000);
    push_out("rst_o_mepc", K_MEPC, 32'h0);
    push_out("rst_o_mie", K_MIE, 32'h0);
    drain();

    rst = 1'b0;
    push_rd("mcycle_first", 12'hB00, 32'h0);
    drain();
    repeat (10) tick();
    push_rd("mcycle_10", 12'hB00, 32'd10);
    push_rd("minstret_0", 12'hB02, 32'd0);
    push_rd("cycle_10", 12'hC00, 32'd10);
    push_rd("mcycleh_0", 12'hB80, 32'd0);
    push_rd("mstatus_idle", 12'h300, 32'h0000_1800);
    push_rd("misa", 12'h301, 32'h4000_0100);
    push_rd("mhartid", 12'hF14, 32'd5);
    push_rd("mip", 12'h344, 32'h0);
    drain();

    wr(12'hB00, 32'hFFFF_FFFF); tick();
    wr(12'hB80, 32'hFFFF_FFFF); tick();
    idle();
    push_rd("wrap_pre_lo", 12'hB00, 32'hFFFF_FFFF);
    push_rd("wrap_pre_hi", 12'hB80, 32'hFFFF_FFFF);
    push_rd("wrap_pre_cycleh", 12'hC80, 32'hFFFF_FFFF);
    drain();
    tick();
    push_rd("wrap_lo", 12'hB00, 32'h0);
    push_rd("wrap_hi", 12'hB80, 32'h0);
    push_rd("wrap_cycle", 12'hC00, 32'h0);
    drain();

    wr(12'hB02, 32'h0000_1234); retire = 1'b1; tick(); idle();
    push_rd("minstret_wr", 12'hB02, 32'h0000_1234);
    push_rd("minstreth_wr", 12'hB82, 32'h0);
    drain();
    retire = 1'b1; tick(); idle();
    push_rd("minstret_inc", 12'hB02, 32'h0000_1235);
    push_rd("instret_shadow", 12'hC02, 32'h0000_1235);
    drain();
    wr(12'hB82, 32'd7); retire = 1'b1; tick(); idle();
    push_rd("minstreth_wr", 12'hB82, 32'd7);
    push_rd("minstret_hold", 12'hB02, 32'h0000_1235);
    push_rd("instreth_shadow", 12'hC82, 32'd7);
    drain();

    wr(12'h300, 32'h8); tick(); idle();
    push_rd("mstatus_wr", 12'h300, 32'h0000_1808);
    push_out("mie_after_wr", K_MIE, 32'h1);
    drain();
    do_trap(32'h8000_0107, 32'h2, 32'h13); tick(); idle();
    push_rd("trap_mepc", 12'h341, 32'h8000_0104);
    push_rd("trap_mcause", 12'h342, 32'h2);
    push_rd("trap_mtval", 12'h343, 32'h13);
    push_rd("trap_mstatus", 12'h300, 32'h0000_1880);
    push_out("trap_o_mie", K_MIE, 32'h0);
    push_out("trap_o_mepc", K_MEPC, 32'h8000_0104);
    drain();
    mret = 1'b1; tick(); idle();
    push_rd("mret_mstatus", 12'h300, 32'h0000_1888);
    push_out("mret_o_mepc", K_MEPC, 32'h8000_0104);
    push_out("mret_o_mie", K_MIE, 32'h1);
    drain();

    wr(12'h340, 32'h0000_A5A5); tick(); idle();
    do_trap(32'h0000_0200, 32'hB, 32'h0); mret = 1'b1; wr(12'h340, 32'h0000_1111);
    tick(); idle();
    push_rd("prio_mscratch", 12'h340, 32'h0000_A5A5);
    push_rd("prio_mepc", 12'h341, 32'h0000_0200);
    push_rd("prio_mcause", 12'h342, 32'hB);
    push_rd("prio_mtval", 12'h343, 32'h0);
    push_rd("prio_mstatus", 12'h300, 32'h0000_1880);
    push_out("prio_o_mie", K_MIE, 32'h0);
    drain();
    mret = 1'b1; wr(12'h300, 32'h0); tick(); idle();
    push_rd("mret_drops_mstatus_wr", 12'h300, 32'h0000_1888);
    drain();
    mret = 1'b1; wr(12'h304, 32'h0000_0888); tick(); idle();
    push_rd("mret_keeps_mie_wr", 12'h304, 32'h0000_0888);
    push_rd("mret_mstatus2", 12'h300, 32'h0000_1888);
    drain();

    wr(12'h305, 32'hFFFF_FFFF); tick(); idle();
    push_out("mtvec_align_o", K_MTVEC, 32'hFFFF_FFFC);
    push_rd("mtvec_align_rd", 12'h305, 32'hFFFF_FFFC);
    drain();
    wr(12'h341, 32'h1234_5677); tick(); idle();
    push_rd("mepc_align_rd", 12'h341, 32'h1234_5674);
    push_out("mepc_align_o", K_MEPC, 32'h1234_5674);
    drain();
    wr(12'hC00, 32'h0); tick(); idle();
    push_rd("cycle_ro_lo", 12'hB00, mcyc_model[31:0]);
    push_rd("cycle_ro_hi", 12'hB80, mcyc_model[63:32]);
    drain();
    wr(12'hF14, 32'h0); tick();
    wr(12'h301, 32'h0); tick();
    wr(12'h7C0, 32'hFFFF_FFFF); tick(); idle();
    push_rd("mhartid_ro", 12'hF14, 32'd5);
    push_rd("misa_ro", 12'h301, 32'h4000_0100);
    push_rd("unimpl_7c0", 12'h7C0, 32'h0, 1'b1);
    drain();

    rst = 1'b1; do_trap(32'h0000_0400, 32'h7, 32'h99); mret = 1'b1;
    wr(12'h340, 32'h0000_DEAD); retire = 1'b1;
    tick();
    rst = 1'b0; idle();
    push_rd("rst2_mstatus", 12'h300, 32'h0000_1800);
    push_rd("rst2_mie", 12'h304, 32'h0);
    push_rd("rst2_mtvec", 12'h305, 32'h0000_1000);
    push_rd("rst2_mscratch", 12'h340, 32'h0);
    push_rd("rst2_mepc", 12'h341, 32'h0);
    push_rd("rst2_mcause", 12'h342, 32'h0);
    push_rd("rst2_mtval", 12'h343, 32'h0);
    push_rd("rst2_mcycle", 12'hB00, 32'h0);
    push_rd("rst2_mcycleh", 12'hB80, 32'h0);
    push_rd("rst2_minstret", 12'hB02, 32'h0);
    push_rd("rst2_minstreth", 12'hB82, 32'h0);
    push_out("rst2_o_mtvec", K_MTVEC, 32'h0000_1000);
    push_out("rst2_o_mepc", K_MEPC, 32'h0);
    push_out("rst2_o_mie", K_MIE, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 Parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec; bits [1:0] are ignored.
REQ-002 Parameter HART_ID, default 32'd0, value returned by mhartid.
REQ-003 i_clk  in  1  single clock; every register updates on its rising edge.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_csr_rd_addr  in  12  CSR read address.
REQ-006 o_csr_rd_data  out  32  combinational read data for i_csr_rd_addr.
REQ-007 o_csr_rd_illegal  out  1  high when i_csr_rd_addr is not an implemented CSR.
REQ-008 i_csr_wr_en  in  1  CSR write strobe, write-back stage.
REQ-009 i_csr_wr_addr  in  12  CSR write address.
REQ-010 i_csr_wr_data  in  32  final write value, already merged by the execute-stage CSR op unit.
REQ-011 i_insn_retire  in  1  one instruction retires this cycle.
REQ-012 i_trap_valid  in  1  take trap this cycle.
REQ-013 i_trap_cause / i_trap_pc / i_trap_tval  in  32 each  mcause, faulting PC, mtval for the trap.
REQ-014 i_mret  in  1  mret commits this cycle.
REQ-015 o_mtvec  out  32  trap vector, direct mode.
REQ-016 o_mepc  out  32  mret return address.
REQ-017 o_mstatus_mie  out  1  global interrupt enable.

Function
REQ-018 Implemented map: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82, mhartid 0xF14.
REQ-019 Reads are combinational with no same-cycle write forwarding; unimplemented address -> data 0, o_csr_rd_illegal=1.
REQ-020 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
REQ-021 misa reads 32'h4000_0100 (RV32I); mip reads 0; mhartid reads HART_ID; writes to these are ignored.
REQ-022 mtvec and mepc bits [1:0] are forced to 0 on every write path.
REQ-023 mie, mscratch, mcause, mtval are full 32-bit read/write.
REQ-024 mcycle: 64-bit counter, +1 every cycle not in reset, wraps 2^64-1 -> 0.
REQ-025 minstret: 64-bit counter, +1 on cycles with i_insn_retire=1, wraps.
REQ-026 Write to 0xB00/0xB02 replaces the low 32 bits and 0xB80/0xB82 the high 32 bits; the other half holds its current value; the increment is suppressed for that counter in that cycle, so the next read returns the written value.
REQ-027 0xC00-0xC82 are read-only shadows of the matching counter halves; writes to any address with [11:10]=2'b11 are ignored.
REQ-028 Writes to unimplemented addresses are ignored.
REQ-029 Trap (i_trap_valid=1), at the clock edge: mepc<=i_trap_pc&~3, mcause<=i_trap_cause, mtval<=i_trap_tval, MPIE<=MIE, MIE<=0.
REQ-030 mret (i_mret=1, no trap), at the clock edge: MIE<=MPIE, MPIE<=1.
REQ-031 Priority: trap > mret > CSR write. With i_trap_valid=1, i_mret and i_csr_wr_en are ignored entirely. With i_mret=1, a CSR write to mstatus is dropped and writes to other CSRs proceed.
REQ-032 Counters keep running on trap and mret cycles. Retire and trap in the same cycle are both honoured.
REQ-033 o_mtvec, o_mepc, o_mstatus_mie are direct register outputs; an update is visible the cycle after the edge.

Reset
REQ-034 On i_rst=1 at an edge: mstatus=32'h0000_1800 (MIE=0, MPIE=0), mie=0, mtvec=MTVEC_RESET&~3, mscratch=0, mepc=0, mcause=0, mtval=0, mcycle=0, minstret=0.
REQ-035 Reset overrides trap, mret, write and increment in the same cycle; mcycle reads 0 on the first cycle after reset is released.

Verification
REQ-036 Release reset, idle 10 cycles -> mcycle=10, minstret=0, read 0x300=0x1800, read 0x301=0x4000_0100.
REQ-037 Write mcycle=0xFFFF_FFFF and mcycleh=0xFFFF_FFFF -> the counter wraps to 0 one cycle after the second write lands; write and retire in the same cycle to minstret -> written value, no +1.
REQ-038 Write mstatus=0x8, then trap with pc=0x8000_0107, cause=0x2, tval=0x13 -> mepc=0x8000_0104, mcause=2, mtval=0x13, mstatus=0x1880, o_mstatus_mie=0.
REQ-039 mret after REQ-038 -> mstatus=0x1888, o_mepc unchanged; trap+mret+write to mscratch in the same cycle -> trap effects only, mscratch unchanged.
REQ-040 Write 0xFFFF_FFFF to mtvec -> o_mtvec=0xFFFF_FFFC; write 0xC00 or 0xF14 -> no change; read 0x7C0 -> data 0, o_csr_rd_illegal=1.
REQ-041 Assert i_rst during a cycle with a trap pending -> all CSRs hold the REQ-034 values afterwards.
